mem_port_arbiter: RTL

//  Shares the single 128-bit memory port between instruction cache (port 0) and data cache (port 1).

---
 rtl/mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between the instruction cache (port 0) and the data
// cache (port 1). One cache owns the port for a whole transaction:
//   read  : one request handshake, then READ_BEATS response beats
//   write : WRITE_BEATS request+data beat pairs
// Ownership is decided only in IDLE, which costs a one-cycle arbitration bubble.
//
// Optional feature macro: ROUND_ROBIN_EN
//   defined   : simultaneous requests go to the cache not granted last
//               (last grant resets to port 1, so port 0 wins the first tie)
//   undefined : fixed priority, port 1 (data cache) wins every tie
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   cN_req_*_i / cN_req_*_o  cache N request and write-data channels (N=0,1)
//   cN_resp_valid_o          response beat for cache N (owner only)
//   cN_resp_data_o           response data, broadcast to both caches
//   mem_req_*_o / mem_*_i    memory-side mirror of the cache channels
//   spurious_resp_o          sticky flag: response beat seen outside RRESP
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_BITS   = 28,
    parameter int DATA_BITS   = 128,
    parameter int READ_BEATS  = 4,
    parameter int WRITE_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   c0_req_valid_i,
    output logic                   c0_req_ready_o,
    input  logic [ADDR_BITS-1:0]   c0_req_addr_i,
    input  logic                   c0_req_rw_i,
    input  logic                   c0_req_data_valid_i,
    output logic                   c0_req_data_ready_o,
    input  logic [DATA_BITS-1:0]   c0_req_data_bits_i,
    input  logic [DATA_BITS/8-1:0] c0_req_data_mask_i,
    output logic                   c0_resp_valid_o,
    output logic [DATA_BITS-1:0]   c0_resp_data_o,

    input  logic                   c1_req_valid_i,
    output logic                   c1_req_ready_o,
    input  logic [ADDR_BITS-1:0]   c1_req_addr_i,
    input  logic                   c1_req_rw_i,
    input  logic                   c1_req_data_valid_i,
    output logic                   c1_req_data_ready_o,
    input  logic [DATA_BITS-1:0]   c1_req_data_bits_i,
    input  logic [DATA_BITS/8-1:0] c1_req_data_mask_i,
    output logic                   c1_resp_valid_o,
    output logic [DATA_BITS-1:0]   c1_resp_data_o,

    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [ADDR_BITS-1:0]   mem_req_addr_o,
    output logic                   mem_req_rw_o,
    output logic                   mem_req_data_valid_o,
    input  logic                   mem_req_data_ready_i,
    output logic [DATA_BITS-1:0]   mem_req_data_bits_o,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask_o,
    input  logic                   mem_resp_valid_i,
    input  logic [DATA_BITS-1:0]   mem_resp_data_i,

    output logic                   spurious_resp_o
);

    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int MAX_BEATS = (READ_BEATS > WRITE_BEATS) ? READ_BEATS : WRITE_BEATS;
    localparam int CNT_BITS  = $clog2(MAX_BEATS) + 1;

    localparam logic [CNT_BITS-1:0] LAST_RBEAT = CNT_BITS'(READ_BEATS - 1);
    localparam logic [CNT_BITS-1:0] LAST_WBEAT = CNT_BITS'(WRITE_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WDATA,
        S_RRESP
    } state_e;

    state_e                state_q;
    logic                  owner_q;     // 0 = icache, 1 = dcache
    logic                  owner_d;     // arbitration winner, used only in IDLE
    logic [CNT_BITS-1:0]   beat_q;
    logic                  spurious_q;
`ifdef ROUND_ROBIN_EN
    logic                  last_grant_q;
`endif

    // Owner-side view of the two cache request channels.
    logic                  own_req_valid;
    logic [ADDR_BITS-1:0]  own_req_addr;
    logic                  own_req_rw;
    logic                  own_data_valid;
    logic [DATA_BITS-1:0]  own_data_bits;
    logic [MASK_BITS-1:0]  own_data_mask;

    assign own_req_valid  = owner_q ? c1_req_valid_i      : c0_req_valid_i;
    assign own_req_addr   = owner_q ? c1_req_addr_i       : c0_req_addr_i;
    assign own_req_rw     = owner_q ? c1_req_rw_i         : c0_req_rw_i;
    assign own_data_valid = owner_q ? c1_req_data_valid_i : c0_req_data_valid_i;
    assign own_data_bits  = owner_q ? c1_req_data_bits_i  : c0_req_data_bits_i;
    assign own_data_mask  = owner_q ? c1_req_data_mask_i  : c0_req_data_mask_i;

    // Arbitration. With a single requester both schemes pick it; they differ
    // only on a tie.
`ifdef ROUND_ROBIN_EN
    assign owner_d = (c0_req_valid_i && c1_req_valid_i) ? ~last_grant_q : c1_req_valid_i;
`else
    assign owner_d = c1_req_valid_i;
`endif

    // Handshakes as seen by the memory. A write data beat accepted together
    // with its request completes the beat without visiting WDATA.
    logic req_fire;
    logic data_fire_req;
    logic data_fire_wdata;

    assign req_fire        = (state_q == S_REQ) && own_req_valid && mem_req_ready_i;
    assign data_fire_req   = (state_q == S_REQ) && own_req_rw && own_data_valid
                             && mem_req_data_ready_i;
    assign data_fire_wdata = (state_q == S_WDATA) && own_data_valid && mem_req_data_ready_i;

    // -------------------------------------------------------------------------
    // Control FSM, owner, beat counter and sticky error flag
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and ordering inside the block is moot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            beat_q       <= '0;
            spurious_q   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            // Any response beat outside the read-response phase has no owner.
            if (mem_resp_valid_i && (state_q != S_RRESP)) begin
                spurious_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (c0_req_valid_i || c1_req_valid_i) begin
                        owner_q      <= owner_d;
`ifdef ROUND_ROBIN_EN
                        last_grant_q <= owner_d;
`endif
                        state_q      <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (req_fire) begin
                        if (!own_req_rw) begin
                            state_q <= S_RRESP;
                            beat_q  <= '0;
                        end else if (data_fire_req) begin
                            if (beat_q == LAST_WBEAT) begin
                                state_q <= S_IDLE;
                                beat_q  <= '0;
                            end else begin
                                state_q <= S_REQ;
                                beat_q  <= beat_q + CNT_BITS'(1);
                            end
                        end else begin
                            state_q <= S_WDATA;
                        end
                    end
                end

                S_WDATA: begin
                    if (data_fire_wdata) begin
                        if (beat_q == LAST_WBEAT) begin
                            state_q <= S_IDLE;
                            beat_q  <= '0;
                        end else begin
                            state_q <= S_REQ;
                            beat_q  <= beat_q + CNT_BITS'(1);
                        end
                    end
                end

                S_RRESP: begin
                    if (mem_resp_valid_i) begin
                        if (beat_q == LAST_RBEAT) begin
                            state_q <= S_IDLE;
                            beat_q  <= '0;
                        end else begin
                            beat_q  <= beat_q + CNT_BITS'(1);
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign spurious_resp_o = spurious_q;

    // -------------------------------------------------------------------------
    // Output steering. Everything is held at 0 while reset is asserted so an
    // abandoned burst cannot complete a handshake in the reset cycle.
    // -------------------------------------------------------------------------
    logic own_req_ready;
    logic own_data_ready;
    logic own_resp_valid;

    // NOTE: every output gets a default before the case statement; without
    // it a state that skips an assignment would infer a latch.
    always_comb begin
        mem_req_valid_o      = 1'b0;
        mem_req_addr_o       = '0;
        mem_req_rw_o         = 1'b0;
        mem_req_data_valid_o = 1'b0;
        mem_req_data_bits_o  = '0;
        mem_req_data_mask_o  = '0;
        own_req_ready        = 1'b0;
        own_data_ready       = 1'b0;
        own_resp_valid       = 1'b0;
        c0_resp_data_o       = '0;
        c1_resp_data_o       = '0;

        if (!reset) begin
            c0_resp_data_o = mem_resp_data_i;
            c1_resp_data_o = mem_resp_data_i;

            case (state_q)
                S_REQ: begin
                    mem_req_valid_o = own_req_valid;
                    mem_req_addr_o  = own_req_addr;
                    mem_req_rw_o    = own_req_rw;
                    own_req_ready   = mem_req_ready_i;
                    if (own_req_rw) begin
                        mem_req_data_valid_o = own_data_valid;
                        mem_req_data_bits_o  = own_data_bits;
                        mem_req_data_mask_o  = own_data_mask;
                        own_data_ready       = mem_req_data_ready_i;
                    end
                end

                S_WDATA: begin
                    mem_req_addr_o       = own_req_addr;
                    mem_req_rw_o         = 1'b1;
                    mem_req_data_valid_o = own_data_valid;
                    mem_req_data_bits_o  = own_data_bits;
                    mem_req_data_mask_o  = own_data_mask;
                    own_data_ready       = mem_req_data_ready_i;
                end

                // The cache keeps req_valid high while waiting for its data;
                // mem_req_valid stays 0 here so the request is not re-issued.
                S_RRESP: begin
                    own_resp_valid = mem_resp_valid_i;
                end

                default: ;
            endcase
        end
    end

    // The non-owner sees every ready and response valid at 0.
    assign c0_req_ready_o      = !owner_q && own_req_ready;
    assign c1_req_ready_o      =  owner_q && own_req_ready;
    assign c0_req_data_ready_o = !owner_q && own_data_ready;
    assign c1_req_data_ready_o =  owner_q && own_data_ready;
    assign c0_resp_valid_o     = !owner_q && own_resp_valid;
    assign c1_resp_valid_o     =  owner_q && own_resp_valid;

endmodule
